// File: rtl/mpc_div_seq_31s_10s_21.sv
// Sequential restoring signed divider (31s / 10s -> 21s saturating quotient), one quotient bit per enabled cycle.
// Optional remainder output port enabled by defining MPC_DIV_REMAINDER_EN.
module mpc_div_seq_31s_10s_21 #(
  parameter int din0_WIDTH = 31,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  div_zero,
  output logic                  ovf
`ifdef MPC_DIV_REMAINDER_EN
  ,
  output logic [din1_WIDTH-1:0] rem
`endif
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int WO = dout_WIDTH;
  localparam int CW = $clog2(W0 + 1);
  localparam logic [WO-1:0]   Q_MAX    = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0]   Q_MIN    = {1'b1, {(WO-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LOAD = CW'(W0);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [W1-1:0]   ZERO_W1  = {W1{1'b0}};
  localparam logic [W1:0]     ZERO_PR  = {(W1+1){1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W0-1:0]   quo_q, quo_d;
  logic [W1-1:0]   dvs_q, dvs_d;
  logic [W1:0]     part_rem_q, part_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [WO-1:0]   dout_q, dout_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;
`ifdef MPC_DIV_REMAINDER_EN
  logic            sgn_dvd_q, sgn_dvd_d;
  logic [W1-1:0]   rem_q, rem_d;
`endif

  logic [W1:0]     shift_s;
  logic [W1:0]     diff_s;
  logic            ge_s;
  logic [W1:0]     rem_nxt_s;
  logic [W0-1:0]   quo_nxt_s;
  logic            ovf_pos_s;
  logic            ovf_neg_s;
  logic [WO-1:0]   sat_dout_s;
  logic            sat_ovf_s;

  // One restoring step plus sign application and saturation of the would-be final quotient.
  always_comb begin
    shift_s   = {part_rem_q[W1-1:0], quo_q[W0-1]};
    ge_s      = ({part_rem_q, quo_q[W0-1]} >= {2'b00, dvs_q});
    diff_s    = shift_s - {1'b0, dvs_q};
    rem_nxt_s = ge_s ? diff_s : shift_s;
    quo_nxt_s = {quo_q[W0-2:0], ge_s};
    // -2^(WO-1) is representable, so the negative limit allows one more magnitude step.
    ovf_pos_s = |quo_nxt_s[W0-1:WO-1];
    ovf_neg_s = (|quo_nxt_s[W0-1:WO]) | (quo_nxt_s[WO-1] & (|quo_nxt_s[WO-2:0]));
    if (neg_quo_q) begin
      sat_ovf_s  = ovf_neg_s;
      sat_dout_s = ovf_neg_s ? Q_MIN : WO'(-quo_nxt_s);
    end else begin
      sat_ovf_s  = ovf_pos_s;
      sat_dout_s = ovf_pos_s ? Q_MAX : quo_nxt_s[WO-1:0];
    end
  end

  // Handshake FSM, iteration counter and datapath next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    part_rem_d  = part_rem_q;
    neg_quo_d   = neg_quo_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;
`ifdef MPC_DIV_REMAINDER_EN
    sgn_dvd_d   = sgn_dvd_q;
    rem_d       = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ce && in_valid && in_ready_q) begin
          quo_d      = din0[W0-1] ? -din0 : din0;
          dvs_d      = din1[W1-1] ? -din1 : din1;
          part_rem_d = ZERO_PR;
          neg_quo_d  = din0[W0-1] ^ din1[W1-1];
          cnt_d      = CNT_LOAD;
          in_ready_d = 1'b0;
          ovf_d      = 1'b0;
          div_zero_d = 1'b0;
`ifdef MPC_DIV_REMAINDER_EN
          sgn_dvd_d  = din0[W0-1];
          rem_d      = ZERO_W1;
`endif
          if (din1 == ZERO_W1) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            div_zero_d  = 1'b1;
            dout_d      = din0[W0-1] ? Q_MIN : Q_MAX;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (ce) begin
          part_rem_d = rem_nxt_s;
          quo_d      = quo_nxt_s;
          cnt_d      = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            dout_d      = sat_dout_s;
            ovf_d       = sat_ovf_s;
`ifdef MPC_DIV_REMAINDER_EN
            rem_d       = sgn_dvd_q ? W1'(-rem_nxt_s) : W1'(rem_nxt_s);
`endif
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (ce && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      quo_q       <= {W0{1'b0}};
      dvs_q       <= ZERO_W1;
      part_rem_q  <= ZERO_PR;
      neg_quo_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dout_q      <= {WO{1'b0}};
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef MPC_DIV_REMAINDER_EN
      sgn_dvd_q   <= 1'b0;
      rem_q       <= ZERO_W1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      part_rem_q  <= part_rem_d;
      neg_quo_q   <= neg_quo_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
`ifdef MPC_DIV_REMAINDER_EN
      sgn_dvd_q   <= sgn_dvd_d;
      rem_q       <= rem_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;
`ifdef MPC_DIV_REMAINDER_EN
  assign rem       = rem_q;
`endif

endmodule

// File: tb/tb_mpc_div_seq_31s_10s_21.sv
// Scoreboard bench for mpc_div_seq_31s_10s_21: expectations queued at issue, checked when out_valid rises.
module tb_mpc_div_seq_31s_10s_21;

  typedef struct {
    logic [20:0] dout;
    logic        dz;
    logic        ovf;
    logic [9:0]  rem;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] din0;
  logic [9:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [20:0] dout;
  logic        div_zero;
  logic        ovf;
`ifdef MPC_DIV_REMAINDER_EN
  logic [9:0]  rem;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   accept_cyc = 0;
  exp_t sb_q[$];

  mpc_div_seq_31s_10s_21 dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .div_zero  (div_zero),
    .ovf       (ovf)
`ifdef MPC_DIV_REMAINDER_EN
    ,
    .rem       (rem)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [20:0] d, input logic z, input logic o, input logic [9:0] r);
    exp_t e;
    e.dout = d; e.dz = z; e.ovf = o; e.rem = r;
    return e;
  endfunction

  // Reference: truncating signed division with saturation to 21 bits.
  function automatic exp_t model(input logic signed [30:0] a, input logic signed [9:0] b);
    exp_t   e;
    longint sa = a;
    longint sb = b;
    longint q;
    if (sb == 0) begin
      e = mk((sa >= 0) ? 21'h0FFFFF : 21'h100000, 1'b1, 1'b0, 10'd0);
    end else begin
      q = sa / sb;
      e.dz  = 1'b0;
      e.rem = 10'(sa % sb);
      if (q > 1048575) begin
        e.dout = 21'h0FFFFF; e.ovf = 1'b1;
      end else if (q < -1048576) begin
        e.dout = 21'h100000; e.ovf = 1'b1;
      end else begin
        e.dout = 21'(q); e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic send(input logic [30:0] a, input logic [9:0] b, input exp_t e);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk);
    accept_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int exp_lat, input int stall_at,
                         input int stall_len, input int hold);
    int          lat = 1;
    exp_t        e;
    logic [20:0] d0;
    if (hold > 0) out_ready = 1'b0;
    while (!out_valid && lat < 300) begin
      if (lat == stall_at) ce = 1'b0;
      if (lat == stall_at + stall_len) ce = 1'b1;
      @(negedge clk); lat++;
    end
    ce = 1'b1;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%b required 1 within 300 cycles", name, out_valid);
      out_ready = 1'b1;
      return;
    end
    if (exp_lat > 0) begin
      n_tests++;
      if (lat !== exp_lat) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
      end
    end
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: got result with empty queue, required pending entry", name);
      e = mk(21'd0, 1'b0, 1'b0, 10'd0);
    end else begin
      e = sb_q.pop_front();
    end
    n_tests++;
    if (dout !== e.dout || div_zero !== e.dz || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL %s_result: dout=%0d dz=%b ovf=%b required dout=%0d dz=%b ovf=%b",
               name, $signed(dout), div_zero, ovf, $signed(e.dout), e.dz, e.ovf);
    end
`ifdef MPC_DIV_REMAINDER_EN
    n_tests++;
    if (rem !== e.rem) begin
      n_fail++;
      $display("FAIL %s_rem: rem=%0d required %0d", name, $signed(rem), $signed(e.rem));
    end
`endif
    d0 = dout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || dout !== d0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_hold%0d: out_valid=%b dout=%0d in_ready=%b required 1 %0d 0",
                 name, i, out_valid, $signed(dout), in_ready, $signed(d0));
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = 31'd0; din1 = 10'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 21'd0 || div_zero !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b dout=%0d dz=%b ovf=%b required 1 0 0 0 0",
               in_ready, out_valid, dout, div_zero, ovf);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    send(31'd12345, 10'd10, mk(21'd1234, 1'b0, 1'b0, 10'd5));        collect("pos_basic", 32, 0, 0, 0);
    send(-31'sd7, 10'd2, mk(-21'sd3, 1'b0, 1'b0, -10'sd1));          collect("neg_dividend", 32, 0, 0, 0);
    send(31'd7, -10'sd2, mk(-21'sd3, 1'b0, 1'b0, 10'd1));            collect("neg_divisor", 32, 0, 0, 0);
    send(-31'sd7, -10'sd2, mk(21'd3, 1'b0, 1'b0, -10'sd1));          collect("both_neg", 32, 0, 0, 0);
  endtask

  task automatic test_div_zero();
    send(31'd5, 10'd0, mk(21'd1048575, 1'b1, 1'b0, 10'd0));          collect("dz_pos", 1, 0, 0, 0);
    send(-31'sd5, 10'd0, mk(21'h100000, 1'b1, 1'b0, 10'd0));         collect("dz_neg", 1, 0, 0, 0);
    send(31'd0, 10'd0, mk(21'd1048575, 1'b1, 1'b0, 10'd0));          collect("dz_zero", 1, 0, 0, 0);
  endtask

  task automatic test_saturation();
    send(31'h40000000, 10'd1, mk(21'h100000, 1'b0, 1'b1, 10'd0));    collect("sat_min", 32, 0, 0, 0);
    send(-31'sd1048576, 10'd1, mk(21'h100000, 1'b0, 1'b0, 10'd0));   collect("exact_min", 32, 0, 0, 0);
    send(31'h20000000, 10'h200, mk(21'h100000, 1'b0, 1'b0, 10'd0));  collect("min_div512", 32, 0, 0, 0);
    send(31'd1048576, 10'd1, mk(21'h0FFFFF, 1'b0, 1'b1, 10'd0));     collect("sat_max", 32, 0, 0, 0);
    send(31'd1048575, 10'd1, mk(21'h0FFFFF, 1'b0, 1'b0, 10'd0));     collect("exact_max", 32, 0, 0, 0);
    send(-31'sd1048577, 10'd1, mk(21'h100000, 1'b0, 1'b1, 10'd0));   collect("sat_min_p1", 32, 0, 0, 0);
  endtask

  task automatic test_ce_stall();
    send(31'd1000000, -10'sd7, mk(-21'sd142857, 1'b0, 1'b0, 10'd1));
    collect("ce_stall", 35, 5, 3, 0);
  endtask

  task automatic test_backpressure();
    send(-31'sd12345, 10'd10, mk(-21'sd1234, 1'b0, 1'b0, -10'sd5));
    collect("backpressure", 32, 0, 0, 5);
  endtask

  task automatic test_reset_mid_calc();
    send(31'd99999, 10'd9, model(31'd99999, 10'd9));
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dout !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: out_valid=%b in_ready=%b dout=%0d required 0 1 0",
               out_valid, in_ready, dout);
    end
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(31'd100, 10'd3, mk(21'd33, 1'b0, 1'b0, 10'd1));
    collect("after_reset", 32, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int first;
    send(31'd54321, 10'd17, model(31'd54321, 10'd17));
    first = accept_cyc;
    collect("b2b_a", 32, 0, 0, 0);
    send(-31'sd999, 10'd0, model(-31'sd999, 10'd0));
    n_tests++;
    if (accept_cyc - first !== 33) begin
      n_fail++;
      $display("FAIL b2b_interval: got %0d required 33", accept_cyc - first);
    end
    collect("b2b_b", 1, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [30:0] a;
    logic [9:0]  b;
    for (int i = 0; i < 16; i++) begin
      a = 31'($urandom) >> $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 1) a = -a;
      b = (i % 5 == 0) ? 10'd0 : 10'($urandom);
      send(a, b, model(a, b));
      collect("random", (b == 10'd0) ? 1 : 32, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_div_zero();
    test_saturation();
    test_ce_stall();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
